// File: rtl/cla8b_result_display.sv
// cla8b_result_display: captures the 9-bit adder result {cout,sum}, converts it to BCD
// with a sequential double-dabble FSM, and scans it onto a 4-digit active-low 7-segment display.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   sum  - adder sum bits [7:0]
//   cout - adder carry-out, bit 8 of the displayed value
//   load - level-sampled capture strobe, honoured only while idle
//   an   - active-low one-hot digit enables (an[0] = ones digit)
//   seg  - active-low segments {g,f,e,d,c,b,a}
//   dp   - active-low decimal point, always off
//   bcd  - last converted value {hundreds,tens,ones}
//   busy - conversion in progress
//   done - one-cycle pulse when bcd and the display update
module cla8b_result_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sum,
    input  logic        cout,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [11:0] bcd,
    output logic        busy,
    output logic        done
);
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t      state_q, state_d;
    logic [8:0]  shift_q, shift_d;
    logic [11:0] work_q, work_d, adj;
    logic [3:0]  iter_q, iter_d;
    logic [11:0] bcd_q, bcd_d;
    logic        done_q, done_d;
    logic [15:0] scan_q, scan_d;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  digit;
    logic        blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift
    always_comb begin
        adj[3:0]  = work_q[3:0]  >= 4'd5 ? work_q[3:0]  + 4'd3 : work_q[3:0];
        adj[7:4]  = work_q[7:4]  >= 4'd5 ? work_q[7:4]  + 4'd3 : work_q[7:4];
        adj[11:8] = work_q[11:8] >= 4'd5 ? work_q[11:8] + 4'd3 : work_q[11:8];
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        work_d  = work_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (load) begin
                shift_d = {cout, sum};
                work_d  = '0;
                iter_d  = '0;
                state_d = CONVERT;
            end
        end else begin
            shift_d = {shift_q[7:0], 1'b0};
            work_d  = {adj[10:0], shift_q[8]};
            iter_d  = iter_q + 4'd1;
            if (iter_q == 4'd8) begin
                bcd_d   = work_d;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    // Display path looks at the next select so an and seg change on the same edge
    always_comb begin
        scan_d = scan_q == SCAN_LAST ? '0 : scan_q + 16'd1;
        sel_d  = scan_q == SCAN_LAST ? sel_q + 2'd1 : sel_q;
        digit  = sel_d == 2'd0 ? bcd_q[3:0] : sel_d == 2'd1 ? bcd_q[7:4] : bcd_q[11:8];
        blank  = sel_d == 2'd3 || (sel_d == 2'd2 && bcd_q[11:8] == 4'd0)
              || (sel_d == 2'd1 && bcd_q[11:4] == 8'd0);
        an_d   = ~(4'b0001 << sel_d);
        seg_d  = blank ? 7'b1111111 : decode(digit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            work_q  <= '0;
            iter_q  <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
            scan_q  <= '0;
            sel_q   <= '0;
            an_q    <= 4'b1110;
            seg_q   <= 7'b1000000;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
            scan_q  <= scan_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;
    assign bcd  = bcd_q;
    assign busy = state_q == CONVERT;
    assign done = done_q;
endmodule

// File: tb/tb_cla8b_result_display.sv
// tb_cla8b_result_display: scoreboard bench for the BCD result display with a decimal reference model.
module tb_cla8b_result_display;
    localparam int SD = 4;
    localparam logic [6:0] LUT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sum = '0;
    logic        cout = 1'b0;
    logic        load = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [11:0] bcd;
    logic        busy;
    logic        done;

    int checks = 0;
    int passes = 0;
    int dones = 0;
    int exp_q[$];

    cla8b_result_display #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .sum(sum), .cout(cout), .load(load),
        .an(an), .seg(seg), .dp(dp), .bcd(bcd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int k);
        if (k == 0) return LUT[v % 10];
        if (k == 1) return v < 10 ? 7'h7F : LUT[(v / 10) % 10];
        if (k == 2) return v < 100 ? 7'h7F : LUT[v / 100];
        return 7'h7F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            dones++;
            if (exp_q.size() == 0) chk("done_expected", 32'(exp_q.size() > 0), 1);
            else chk("bcd_result", bcd, to_bcd(exp_q.pop_front()));
        end
    end

    task automatic load_val(input int v, input bit track);
        int n;
        @(negedge clk);
        sum  = v[7:0];
        cout = v[8];
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        if (track) exp_q.push_back(v);
        n = 0;
        while (busy && n < 20) begin
            sum  = 8'($urandom);
            cout = 1'($urandom);
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, 9);
    endtask

    task automatic check_display(input int v);
        logic [3:0] want;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            int n;
            want = ~(4'b0001 << k);
            n = 0;
            while (an !== want && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("an_reached", 32'(n < 40), 1);
            chk($sformatf("seg_digit%0d", k), seg, exp_seg(v, k));
        end
    endtask

    initial begin
        int d0;
        int n;
        logic [3:0] want;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_bcd", bcd, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("dp_off", dp, 1);
        for (int k = 0; k <= 16; k++) begin
            want = ~(4'b0001 << ((k / SD) % 4));
            chk("scan_an", an, want);
            chk("scan_seg", seg, exp_seg(0, (k / SD) % 4));
            @(negedge clk);
        end
        load_val(511, 1);
        check_display(511);
        load_val(7, 1);
        check_display(7);
        // second load during conversion must be ignored
        d0 = dones;
        @(negedge clk);
        sum = 8'd200; cout = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        exp_q.push_back(200);
        repeat (2) @(negedge clk);
        sum = 8'd99; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("ignored_load_bcd", bcd, to_bcd(200));
        chk("ignored_load_dones", dones - d0, 1);
        // reset mid-conversion aborts without a done pulse
        d0 = dones;
        @(negedge clk);
        sum = 8'd123; cout = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_no_done", dones - d0, 0);
        chk("abort_busy", busy, 0);
        chk("abort_bcd", bcd, 0);
        load_val(45, 1);
        check_display(45);
        for (int i = 0; i < 15; i++) begin
            int v;
            v = int'($urandom_range(0, 511));
            load_val(v, 1);
            if (i % 4 == 0) check_display(v);
        end
        // asynchronous reset between clock edges takes effect immediately
        @(negedge clk);
        sum = 8'hA5; cout = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_an", an, 4'b1110);
        chk("async_seg", seg, 7'b1000000);
        chk("async_bcd", bcd, 0);
        chk("async_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
